// File: rtl/zmodem_pkg.sv
// ZMODEM receive-path constants, FSM encoding and byte classifiers.
// Shared by the ZDLE decoder and the transmit-side escaper.
package zmodem_pkg;

    localparam logic [7:0] ZDLE   = 8'h18;
    localparam logic [7:0] ZCRCE  = 8'h68;
    localparam logic [7:0] ZCRCG  = 8'h69;
    localparam logic [7:0] ZCRCQ  = 8'h6A;
    localparam logic [7:0] ZCRCW  = 8'h6B;
    localparam logic [7:0] ZRUB0  = 8'h6C;
    localparam logic [7:0] ZRUB1  = 8'h6D;
    localparam logic [7:0] XON    = 8'h11;
    localparam logic [7:0] XOFF   = 8'h13;
    localparam logic [7:0] XON_P  = 8'h91;
    localparam logic [7:0] XOFF_P = 8'h93;

    localparam logic [2:0] CAN_ABORT_COUNT = 3'd5;

    typedef enum logic {
        NORMAL = 1'b0,
        ESCAPE = 1'b1
    } zdle_state_t;

    function automatic logic is_flow(input logic [7:0] b);
        return (b == XON) || (b == XOFF) || (b == XON_P) || (b == XOFF_P);
    endfunction

    function automatic logic is_marker(input logic [7:0] b);
        return (b >= ZCRCE) && (b <= ZCRCW);
    endfunction

endpackage

// File: rtl/zdle_fifo.sv
// Synchronous show-ahead FIFO; head entry visible on rd_data while !empty.
// Pointers carry one extra wrap bit so full/empty need no counter.
module zdle_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_rd = rd_en && !empty && !clear;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_wr = wr_en && (!full || do_rd) && !clear;

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + ONE;
            if (do_rd) rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/zdle_decoder.sv
// ZMODEM receive unescaper: strips ZDLE escapes and XON/XOFF, flags
// frame-end markers, detects 5xCAN abort, buffers into a show-ahead FIFO.
module zdle_decoder
    import zmodem_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic [7:0] out_data,
    output logic       out_marker,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       cancel,
    output logic       bad_escape,
    output logic       overflow
);

    zdle_state_t state, state_n;
    logic [2:0]  can_cnt, can_cnt_n;
    logic        act;
    logic        emit;
    logic [8:0]  emit_word;
    logic        cancel_d;
    logic        bad_d;
    logic [8:0]  head;
    logic        full;
    logic        empty;

    assign act = in_valid && !clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= NORMAL;
            can_cnt <= '0;
        end else if (clear) begin
            state   <= NORMAL;
            can_cnt <= '0;
        end else begin
            state   <= state_n;
            can_cnt <= can_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        can_cnt_n = can_cnt;
        if (act) begin
            unique case (state)
                NORMAL: begin
                    can_cnt_n = '0;
                    if (in_data == ZDLE) begin
                        state_n   = ESCAPE;
                        can_cnt_n = 3'd1;
                    end
                end
                ESCAPE: begin
                    if (in_data == ZDLE) begin
                        if (can_cnt + 3'd1 == CAN_ABORT_COUNT) begin
                            state_n   = NORMAL;
                            can_cnt_n = '0;
                        end else begin
                            can_cnt_n = can_cnt + 3'd1;
                        end
                    end else if (!is_flow(in_data)) begin
                        state_n   = NORMAL;
                        can_cnt_n = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        emit      = 1'b0;
        emit_word = {1'b0, in_data};
        cancel_d  = 1'b0;
        bad_d     = 1'b0;
        if (act) begin
            unique case (state)
                NORMAL: begin
                    emit = (in_data != ZDLE) && !is_flow(in_data);
                end
                ESCAPE: begin
                    if (in_data == ZDLE) begin
                        cancel_d = (can_cnt + 3'd1 == CAN_ABORT_COUNT);
                    end else if (is_flow(in_data)) begin
                        emit = 1'b0;
                    end else if (is_marker(in_data)) begin
                        emit      = 1'b1;
                        emit_word = {1'b1, in_data};
                    end else if (in_data == ZRUB0) begin
                        emit      = 1'b1;
                        emit_word = {1'b0, 8'h7F};
                    end else if (in_data == ZRUB1) begin
                        emit      = 1'b1;
                        emit_word = {1'b0, 8'hFF};
                    end else if ((in_data & 8'h60) == 8'h40) begin
                        emit      = 1'b1;
                        emit_word = {1'b0, in_data ^ 8'h40};
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cancel     <= 1'b0;
            bad_escape <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            cancel     <= 1'b0;
            bad_escape <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            cancel     <= cancel_d;
            bad_escape <= bad_d;
            // full implies non-empty, so out_ready alone means a pop happens
            if (emit && full && !out_ready) overflow <= 1'b1;
        end
    end

    zdle_fifo #(
        .WIDTH(9),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .wr_en  (emit),
        .wr_data(emit_word),
        .rd_en  (out_ready),
        .rd_data(head),
        .full   (full),
        .empty  (empty)
    );

    assign out_valid  = !empty;
    assign out_data   = out_valid ? head[7:0] : 8'h00;
    assign out_marker = out_valid && head[8];

endmodule

// File: doc/zdle_decoder.md
# zdle_decoder

Receive-side ZMODEM byte unescaper that sits directly downstream of the UART receiver. It consumes the single-cycle `rx_data`/`rx_valid` byte stream, strips ZDLE escapes and flow-control characters, flags frame-end markers, and detects the 5×CAN abort sequence. Decoded bytes are buffered in a small FIFO and presented on a valid/ready interface to the ZMODEM protocol engine.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous flush of FSM, CAN counter, FIFO and `overflow`.
- `in_data` input 8: received byte, driven by UART `rx_data`.
- `in_valid` input 1: one-cycle strobe per byte, driven by `rx_valid`. Back-to-back strobes are legal. There is no backpressure.
- `out_data` output 8: decoded byte, or the raw marker code when `out_marker`=1.
- `out_marker` output 1: entry is a ZCRCE/ZCRCG/ZCRCQ/ZCRCW frame-end marker.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: consumer accepts the head entry when `out_valid`&&`out_ready`.
- `cancel` output 1: one-cycle pulse on the 5th consecutive 0x18.
- `bad_escape` output 1: one-cycle pulse on an illegal byte following ZDLE.
- `overflow` output 1: sticky. Set when a decoded entry is dropped on a full FIFO.

## Operation
- After reset, all outputs are 0: `out_data`=0x00, `out_marker`=0, `out_valid`=0, `cancel`=0, `bad_escape`=0, `overflow`=0. FSM=NORMAL, `can_cnt`=0, FIFO empty.
- The FSM has 2 states, NORMAL and ESCAPE. It acts only on cycles where `in_valid`=1.
- In NORMAL:
  - 0x18 (ZDLE): go to ESCAPE, set `can_cnt`=1, emit nothing.
  - 0x11, 0x13, 0x91, 0x93 (XON/XOFF): drop silently.
  - Any other byte: emit it as data (`marker`=0).
- In ESCAPE:
  - 0x18: increment `can_cnt`. When it reaches 5: pulse `cancel`, go to NORMAL, set `can_cnt`=0. Otherwise stay in ESCAPE.
  - 0x68–0x6B: emit the byte with `marker`=1, go to NORMAL.
  - 0x6C (ZRUB0): emit 0x7F. 0x6D (ZRUB1): emit 0xFF. Go to NORMAL.
  - 0x11, 0x13, 0x91, 0x93: drop and stay in ESCAPE. `can_cnt` keeps its value.
  - `(b & 0x60)==0x40`: emit `b ^ 0x40`, go to NORMAL.
  - Any other byte: pulse `bad_escape`, emit nothing, go to NORMAL.
- Any non-0x18 byte clears `can_cnt`, except XON/XOFF received in ESCAPE.
- `cancel` does not flush the FIFO; the consumer decides what to do.
- FIFO entries are 9 bits wide ({marker, data}) and show-ahead: `out_data`/`out_marker` reflect the head entry whenever `out_valid`=1.
- If an emit occurs with the FIFO full and no pop in the same cycle, the entry is dropped and `overflow` is set.
- If the FIFO is full and a pop occurs in the same cycle, the write succeeds.
- `clear` takes priority over `in_valid` and `out_ready` in the same cycle. `in_valid` is ignored during that cycle.
- Asserting `reset` mid-frame returns the block to its reset state immediately. Any partial escape is discarded.

## Timing
- Byte strobed at cycle N is registered into the FIFO at the N→N+1 edge. With the FIFO empty, `out_valid`=1 at N+1 with the decoded data.
- `cancel` and `bad_escape` are registered and assert at N+1 for exactly 1 cycle.
- Sustained throughput is 1 byte per cycle in and 1 entry per cycle out.
- Empty FIFO with simultaneous write and `out_ready`: there is no bypass. The entry appears at N+1.
- The FIFO pointers are log2(DEPTH)+1 bits, and full/empty are derived from the MSB comparison. Wrap-around must be exact at DEPTH.
- `overflow` is set at the N→N+1 edge of the dropped write.

## Structure
- Package `zmodem_pkg` holds:
  - ZDLE=0x18, ZCRCE=0x68, ZCRCG=0x69, ZCRCQ=0x6A, ZCRCW=0x6B
  - ZRUB0=0x6C, ZRUB1=0x6D
  - XON/XOFF codes 0x11, 0x13, 0x91, 0x93
  - CAN_ABORT_COUNT=5
  - FSM state encoding
- Sub-module `zdle_fifo`: synchronous show-ahead FIFO with parameterised width and depth, plus `full`/`empty` flags. It is reusable by the TX path.
- The FSM, the CAN counter and the output pulses live in `zdle_decoder`.

## Test plan
- Stream 0x41, 0x18, 0x58, 0x18, 0x4D, `out_ready`=1 → outputs 0x41, 0x18, 0x0D, all with `marker`=0. Each appears one cycle after its final input byte.
- 0x18 0x6B, then 0x18 0x6C, then 0x18 0x6D → outputs {marker=1, 0x6B}, 0x7F, 0xFF.
- Five consecutive 0x18 → `cancel` pulses once, 1 cycle after the 5th byte, with no output. A following 0x42 is emitted normally.
- 0x11, 0x18, 0x13, 0x48 → single output 0x08. Then 0x18 0x20 → `bad_escape` pulse and no output.
- `out_ready`=0, DEPTH+1 data bytes → DEPTH entries held and `overflow`=1. Then pulse `clear` → `out_valid`=0 and `overflow`=0.
- Assert `reset` between 0x18 and 0x58 → all outputs 0. A following 0x58 is emitted as 0x58, not 0x18.
